systolic_tile_sequencer: RTL
============================

Name: systolic_tile_sequencer

Overview:
- Hardware replacement for the tile-level skew/de-skew sequencing that currently lives in the array testbench.
- Sits between a tile-row source/sink and a linear posit systolic array of SIZE lanes.
- Accepts a command: preload A weights (LOAD_A) or stream B/C through the array (MATMUL).
- Buffers one SIZE x SIZE tile, drives the diagonally skewed lane inputs and prop flags, de-skews the C results, and returns them row by row with a valid/ready handshake.

Parameters:
- SIZE, 4, number of array lanes; tile is SIZE x SIZE.
- WIDTH, 16, posit element width of A/B.
- ACC_WIDTH, 81, accumulator (quire) width of C.
- ARRAY_LAT, 4, cycles from a lane's B/C input to the matching C output on the same lane (must be >= 1).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = LOAD_A, 1 = MATMUL.
- row_valid  in  1  input tile row valid.
- row_ready  out  1  high only in FILL.
- row_ab  in  SIZE*WIDTH  A row (LOAD_A) or B row (MATMUL); lane j = bits [j*WIDTH +: WIDTH].
- row_c  in  SIZE*ACC_WIDTH  C-init row; used in MATMUL only.
- row_c_zero  in  SIZE  per-lane C zero flag.
- row_c_nan  in  SIZE  per-lane C NaN flag.
- arr_A_in  out  SIZE*WIDTH  to array.
- arr_prop_in  out  SIZE  to array.
- arr_B_in  out  SIZE*WIDTH  to array.
- arr_C_in  out  SIZE*ACC_WIDTH  to array.
- arr_C_in_zero  out  SIZE  to array.
- arr_C_in_nan  out  SIZE  to array.
- arr_C_out  in  SIZE*ACC_WIDTH  from array.
- arr_C_out_zero  in  SIZE  from array.
- arr_C_out_nan  in  SIZE  from array.
- out_valid  out  1  result row valid.
- out_ready  in  1  result row accept.
- out_c  out  SIZE*ACC_WIDTH  result row.
- out_c_zero  out  SIZE  result zero flags.
- out_c_nan  out  SIZE  result NaN flags.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, FILL, STREAM, EMIT.
- IDLE -> FILL: on cmd_valid & cmd_ready; latch cmd_op; clear row counter.
- FILL: each row_valid & row_ready stores the row into buffer row r (r = 0..SIZE-1). Gaps in row_valid are allowed. After row SIZE-1 is stored, go to STREAM with t = 0 on the next cycle.
- STREAM: counter t increments by 1 each cycle. All arr_* outputs are registered, so "cycle t" means the cycle in which arr_* present the value for index t. Lane j is active when 0 <= t-j < SIZE.
  - LOAD_A: active lane gets arr_A_in[j] = bufA[SIZE-1-(t-j)][j] and arr_prop_in[j] = 0. Inactive lane gets A = 0, prop = 1. B/C outputs = 0. STREAM lasts 2*SIZE-1 cycles, then IDLE.
  - MATMUL: arr_A_in = 0 and arr_prop_in = all 1 throughout. Active lane gets B = bufB[t-j][j], C/zero/nan = bufC[t-j][j]; inactive lane gets 0.
  - MATMUL capture: in cycle t, lane j's arr_C_out* is sampled into result row (t-ARRAY_LAT-j) when 0 <= t-ARRAY_LAT-j < SIZE. STREAM ends after t = ARRAY_LAT+2*SIZE-2, then EMIT.
- EMIT: present result rows 0..SIZE-1 in order; out_valid = 1. Advance on out_valid & out_ready. out_* stay stable while out_ready is low. After row SIZE-1 is accepted, go to IDLE. The result buffer may reuse the input C buffer.
- Idle drive: outside active STREAM slots, arr_A_in = 0, arr_prop_in = all 1, B/C/zero/nan = 0.
- Reset values: state IDLE; cmd_ready = 1 (first cycle after reset); row_ready = 0; out_valid = 0; busy = 0; out_* = 0; arr_* at idle drive. Buffer contents are don't-care.
- Reset in any state: return to IDLE on the next edge and discard the partial tile or results. No output handshake completes in that cycle.
- cmd_valid outside IDLE is ignored (not queued).
- A new command is accepted only after returning to IDLE, so the earliest is the cycle after the last STREAM (LOAD_A) or EMIT handshake.
- No arithmetic. Pure data steering; widths are passed through unchanged.

Test Plan:
- LOAD_A, SIZE=4, A[r][c] = 16'h(r*16+c):
  - Cycles t=0..6 on arr_A_in/prop match the skew rule.
  - Lane 0 at t=0 carries 16'h0030 with prop 0.
  - Lane 3 at t=0 carries A = 0 with prop 1.
  - busy drops after t=6.
- MATMUL with a loopback array model (each lane delays B, zero-extended, by ARRAY_LAT cycles into C_out):
  - out rows equal the input B rows in order.
  - Zero/NaN flags are returned per element, e.g. C_zero[2][1] = 1 comes back as out row 2, bit 1.
- ARRAY_LAT=7 loopback: same result ordering; STREAM lasts 7+2*4-1 = 14 cycles.
- row_valid toggled every other cycle during FILL: STREAM starts exactly one cycle after the 4th accepted row.
- out_ready held low 5 cycles during EMIT row 1: out_c stays stable; all 4 rows arrive exactly once, in order.
- reset asserted at STREAM t=3, then a fresh LOAD_A command:
  - Outputs return to idle drive the next cycle.
  - cmd_ready = 1 the cycle after reset deasserts.
  - The new sequence is correct.

Source files
------------

// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer for a linear posit systolic array: buffers one SIZE x SIZE tile,
// drives the diagonally skewed lane inputs, de-skews C results and emits them row by row.
module systolic_tile_sequencer #(
    parameter int SIZE      = 4,
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 81,
    parameter int ARRAY_LAT = 4
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_op_i,
    input  logic                      row_valid_i,
    output logic                      row_ready_o,
    input  logic [SIZE*WIDTH-1:0]     row_ab_i,
    input  logic [SIZE*ACC_WIDTH-1:0] row_c_i,
    input  logic [SIZE-1:0]           row_c_zero_i,
    input  logic [SIZE-1:0]           row_c_nan_i,
    output logic [SIZE*WIDTH-1:0]     arr_A_in_o,
    output logic [SIZE-1:0]           arr_prop_in_o,
    output logic [SIZE*WIDTH-1:0]     arr_B_in_o,
    output logic [SIZE*ACC_WIDTH-1:0] arr_C_in_o,
    output logic [SIZE-1:0]           arr_C_in_zero_o,
    output logic [SIZE-1:0]           arr_C_in_nan_o,
    input  logic [SIZE*ACC_WIDTH-1:0] arr_C_out_i,
    input  logic [SIZE-1:0]           arr_C_out_zero_i,
    input  logic [SIZE-1:0]           arr_C_out_nan_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [SIZE*ACC_WIDTH-1:0] out_c_o,
    output logic [SIZE-1:0]           out_c_zero_o,
    output logic [SIZE-1:0]           out_c_nan_o,
    output logic                      busy_o
);
    localparam int RW         = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int T_LOAD_END = 2*SIZE - 2;
    localparam int T_MM_END   = ARRAY_LAT + 2*SIZE - 2;
    localparam int TW         = $clog2(T_MM_END + 2);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_STREAM, ST_EMIT} state_t;

    state_t              state_q, state_d;
    logic                op_q, op_d;
    logic [RW-1:0]       row_cnt_q, row_cnt_d, emit_q, emit_d;
    logic [TW-1:0]       t_q, t_d;
    logic                cmd_ready_q, row_ready_q, busy_q, out_valid_q, out_valid_d;

    // Tile buffers; the C buffer doubles as the result buffer during MATMUL.
    logic [SIZE*WIDTH-1:0]     ab_q [SIZE];
    logic [SIZE*WIDTH-1:0]     ab_d [SIZE];
    logic [SIZE*ACC_WIDTH-1:0] c_q  [SIZE];
    logic [SIZE*ACC_WIDTH-1:0] c_d  [SIZE];
    logic [SIZE-1:0]           cz_q [SIZE];
    logic [SIZE-1:0]           cz_d [SIZE];
    logic [SIZE-1:0]           cn_q [SIZE];
    logic [SIZE-1:0]           cn_d [SIZE];

    logic [SIZE*WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [SIZE-1:0]           prop_q, prop_d, czin_q, czin_d, cnin_q, cnin_d;
    logic [SIZE*ACC_WIDTH-1:0] cin_q, cin_d, out_c_q, out_c_d;
    logic [SIZE-1:0]           out_z_q, out_z_d, out_n_q, out_n_d;

    always_comb begin
        int d;
        d         = 0;
        state_d   = state_q;
        op_d      = op_q;
        row_cnt_d = row_cnt_q;
        t_d       = t_q;
        emit_d    = emit_q;
        ab_d      = ab_q;
        c_d       = c_q;
        cz_d      = cz_q;
        cn_d      = cn_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    state_d   = ST_FILL;
                    op_d      = cmd_op_i;
                    row_cnt_d = '0;
                end
            end
            ST_FILL: begin
                if (row_valid_i && row_ready_q) begin
                    ab_d[row_cnt_q] = row_ab_i;
                    c_d[row_cnt_q]  = row_c_i;
                    cz_d[row_cnt_q] = row_c_zero_i;
                    cn_d[row_cnt_q] = row_c_nan_i;
                    if (row_cnt_q == RW'(SIZE-1)) begin
                        state_d = ST_STREAM;
                        t_d     = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + RW'(1);
                    end
                end
            end
            ST_STREAM: begin
                if (op_q) begin
                    for (int j = 0; j < SIZE; j++) begin
                        d = int'(t_q) - ARRAY_LAT - j;
                        if (d >= 0 && d < SIZE) begin
                            c_d[RW'(d)][j*ACC_WIDTH +: ACC_WIDTH] = arr_C_out_i[j*ACC_WIDTH +: ACC_WIDTH];
                            cz_d[RW'(d)][j] = arr_C_out_zero_i[j];
                            cn_d[RW'(d)][j] = arr_C_out_nan_i[j];
                        end
                    end
                end
                if (!op_q && t_q == TW'(T_LOAD_END)) begin
                    state_d = ST_IDLE;
                end else if (op_q && t_q == TW'(T_MM_END)) begin
                    state_d = ST_EMIT;
                    emit_d  = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            ST_EMIT: begin
                if (out_valid_q && out_ready_i) begin
                    if (emit_q == RW'(SIZE-1)) state_d = ST_IDLE;
                    else                       emit_d  = emit_q + RW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Lane drive for the next cycle's index; the just-written row is visible via ab_d.
        a_d    = '0;
        prop_d = '1;
        b_d    = '0;
        cin_d  = '0;
        czin_d = '0;
        cnin_d = '0;
        if (state_d == ST_STREAM) begin
            for (int j = 0; j < SIZE; j++) begin
                d = int'(t_d) - j;
                if (d >= 0 && d < SIZE) begin
                    if (!op_d) begin
                        a_d[j*WIDTH +: WIDTH] = ab_d[RW'(SIZE-1-d)][j*WIDTH +: WIDTH];
                        prop_d[j]             = 1'b0;
                    end else begin
                        b_d[j*WIDTH +: WIDTH]           = ab_d[RW'(d)][j*WIDTH +: WIDTH];
                        cin_d[j*ACC_WIDTH +: ACC_WIDTH] = c_d[RW'(d)][j*ACC_WIDTH +: ACC_WIDTH];
                        czin_d[j]                       = cz_d[RW'(d)][j];
                        cnin_d[j]                       = cn_d[RW'(d)][j];
                    end
                end
            end
        end

        out_valid_d = (state_d == ST_EMIT);
        out_c_d     = out_valid_d ? c_d[emit_d]  : '0;
        out_z_d     = out_valid_d ? cz_d[emit_d] : '0;
        out_n_d     = out_valid_d ? cn_d[emit_d] : '0;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            op_q        <= 1'b0;
            row_cnt_q   <= '0;
            emit_q      <= '0;
            t_q         <= '0;
            cmd_ready_q <= 1'b1;
            row_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            out_z_q     <= '0;
            out_n_q     <= '0;
            a_q         <= '0;
            prop_q      <= '1;
            b_q         <= '0;
            cin_q       <= '0;
            czin_q      <= '0;
            cnin_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            row_cnt_q   <= row_cnt_d;
            emit_q      <= emit_d;
            t_q         <= t_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            row_ready_q <= (state_d == ST_FILL);
            busy_q      <= (state_d != ST_IDLE);
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
            out_z_q     <= out_z_d;
            out_n_q     <= out_n_d;
            a_q         <= a_d;
            prop_q      <= prop_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            czin_q      <= czin_d;
            cnin_q      <= cnin_d;
        end
    end

    always_ff @(posedge clock_i) begin
        ab_q <= ab_d;
        c_q  <= c_d;
        cz_q <= cz_d;
        cn_q <= cn_d;
    end

    assign cmd_ready_o     = cmd_ready_q;
    assign row_ready_o     = row_ready_q;
    assign busy_o          = busy_q;
    assign out_valid_o     = out_valid_q;
    assign out_c_o         = out_c_q;
    assign out_c_zero_o    = out_z_q;
    assign out_c_nan_o     = out_n_q;
    assign arr_A_in_o      = a_q;
    assign arr_prop_in_o   = prop_q;
    assign arr_B_in_o      = b_q;
    assign arr_C_in_o      = cin_q;
    assign arr_C_in_zero_o = czin_q;
    assign arr_C_in_nan_o  = cnin_q;
endmodule
